// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: resolves EX-stage branches/jumps, redirects the PC and
// holds a flush window over the wrong-path instructions behind a redirect.
module pc_redirect_unit #(
   parameter int                AWIDTH       = 32,
   parameter logic [AWIDTH-1:0] BASEADDR     = 32'h0100_0000,
   parameter int                FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_i,
   input  logic              ex_valid_i,
   input  logic [6:0]        opcode_i,
   input  logic [2:0]        funct3_i,
   input  logic              breq_i,
   input  logic              brlt_i,
   input  logic [AWIDTH-1:0] target_i,
   output logic [AWIDTH-1:0] pc_o,
   output logic              flush_o,
   output logic              taken_o,
   output logic              misaligned_o,
   output logic              illegal_o,
   output logic [31:0]       redirect_cnt_o
);

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t            state_reg, state_next;
   logic [2:0]        cnt_reg, cnt_next;
   logic [AWIDTH-1:0] pc_reg, pc_next;
   logic              taken_reg, misaligned_reg, illegal_reg;
   logic [31:0]       redirect_cnt_reg;

   logic              taken, bad_branch, active, redirect, illegal;
   logic [AWIDTH-1:0] eff_target;

   // Branch condition decode; funct3 010/011 are not defined for BRANCH.
   always_comb begin
      taken      = 1'b0;
      bad_branch = 1'b0;
      case (opcode_i)
         OP_BRANCH: begin
            case (funct3_i)
               3'b000:         taken = breq_i;
               3'b001:         taken = ~breq_i;
               3'b100, 3'b110: taken = brlt_i;
               3'b101, 3'b111: taken = ~brlt_i;
               default:        bad_branch = 1'b1;
            endcase
         end
         OP_JAL, OP_JALR: taken = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      eff_target = target_i;
      if (opcode_i == OP_JALR)
         eff_target[0] = 1'b0;
   end

   // Anything arriving while flushing is wrong-path and is ignored.
   assign active   = ex_valid_i & ~stall_i & (state_reg == RUN);
   assign redirect = active & taken;
   assign illegal  = active & bad_branch;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         RUN: begin
            if (redirect) begin
               state_next = FLUSH;
               cnt_next   = 3'(FLUSH_CYCLES - 1);
            end
         end
         FLUSH: begin
            if (!stall_i) begin
               if (cnt_reg == 3'd0)
                  state_next = RUN;
               else
                  cnt_next = cnt_reg - 3'd1;
            end
         end
         default: state_next = RUN;
      endcase
   end

   always_comb begin
      if (redirect)
         pc_next = eff_target;
      else if (stall_i)
         pc_next = pc_reg;
      else
         pc_next = pc_reg + AWIDTH'(4);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= RUN;
         cnt_reg          <= 3'd0;
         pc_reg           <= BASEADDR;
         taken_reg        <= 1'b0;
         misaligned_reg   <= 1'b0;
         illegal_reg      <= 1'b0;
         redirect_cnt_reg <= 32'd0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         pc_reg         <= pc_next;
         misaligned_reg <= redirect & (eff_target[1:0] != 2'b00);
         illegal_reg    <= illegal;
         if (!stall_i)
            taken_reg <= redirect;
         if (redirect)
            redirect_cnt_reg <= redirect_cnt_reg + 32'd1;
      end
   end

   assign pc_o           = pc_reg;
   assign flush_o        = (state_reg == FLUSH);
   assign taken_o        = taken_reg;
   assign misaligned_o   = misaligned_reg;
   assign illegal_o      = illegal_reg;
   assign redirect_cnt_o = redirect_cnt_reg;

endmodule
